// File: rtl/dot_pkg.sv
// dot_pkg: shared widths, phase order and dot-product helper for the dot engine
// and its serializer.
package dot_pkg;
    localparam int DW = 8;
    localparam int RW = 2*DW+2;
    localparam int NUM_PHASES = 6;
    typedef enum logic [2:0] {PH_A0, PH_A1, PH_A2, PH_B0, PH_B1, PH_B2} phase_t;
    function automatic logic [RW-1:0] dot3(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int i = 0; i < 3; i++)
            s += RW'(a[i*DW +: DW]) * RW'(b[i*DW +: DW]);
        return s;
    endfunction
endpackage

// File: rtl/dot_result_checker.sv
// dot_result_checker: predicts the engine's result one frame behind the
// serializer and flags a missing, spurious or wrong result strobe.
module dot_result_checker
    import dot_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            last,
    input  logic            first,
    input  logic [6*DW-1:0] next_frame,
    input  logic            res_valid,
    input  logic [RW-1:0]   res_data,
    output logic            chk_mismatch,
    output logic            chk_err
);
    logic [RW-1:0] exp_cur, exp_prev;
    logic          seen, armed;
    // the engine drives a junk strobe out of reset, so checking waits two frames
    assign chk_mismatch = armed && (first ? (!res_valid || res_data != exp_prev) : res_valid);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_cur  <= '0;
            exp_prev <= '0;
            seen     <= 1'b0;
            armed    <= 1'b0;
            chk_err  <= 1'b0;
        end else begin
            if (last) begin
                exp_cur  <= dot3(next_frame[3*DW-1:0], next_frame[6*DW-1:3*DW]);
                exp_prev <= exp_cur;
                seen     <= 1'b1;
                armed    <= seen;
            end
            if (chk_mismatch)
                chk_err <= 1'b1;
        end
    end
endmodule

// File: rtl/dot_vec_serializer.sv
// dot_vec_serializer: streams vector pairs a0..b2 in lock-step with the dot engine's
// 6-phase sequence, padding with zero frames; result check under DOT_RESULT_CHECK_EN.
module dot_vec_serializer #(
    parameter  int DW = 8,
    localparam int RW = 2*DW+2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*DW-1:0] in_a,
    input  logic [3*DW-1:0] in_b,
    output logic [DW-1:0]   byte_o,
    output logic            frame_start,
    output logic            frame_last,
    output logic [15:0]     frames_sent,
    input  logic            res_valid,
    input  logic [RW-1:0]   res_data,
    output logic            chk_mismatch,
    output logic            chk_err
);
    import dot_pkg::*;
    phase_t          phase;
    logic            hold_full, frame_live, last, accept;
    logic [6*DW-1:0] hold, frame_reg, next_frame;
    assign last        = phase == PH_B2;
    assign in_ready    = !hold_full || last;
    assign accept      = in_valid && in_ready;
    assign next_frame  = hold_full ? hold : '0;
    assign byte_o      = frame_reg[phase*DW +: DW];
    assign frame_start = frame_live && phase == PH_A0;
    assign frame_last  = last;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase       <= PH_A0;
            hold_full   <= 1'b0;
            hold        <= '0;
            frame_reg   <= '0;
            frame_live  <= 1'b0;
            frames_sent <= '0;
        end else begin
            phase <= last ? PH_A0 : phase_t'(phase + 3'd1);
            if (last) begin
                frame_reg  <= next_frame;
                frame_live <= hold_full;
                hold_full  <= accept;
                if (hold_full)
                    frames_sent <= frames_sent + 16'd1;
            end else begin
                hold_full <= hold_full | accept;
            end
            if (accept)
                hold <= {in_b, in_a};
        end
    end
`ifdef DOT_RESULT_CHECK_EN
    dot_result_checker u_chk (
        .clk          (clk),
        .resetn       (resetn),
        .last         (last),
        .first        (phase == PH_A0),
        .next_frame   (next_frame),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .chk_mismatch (chk_mismatch),
        .chk_err      (chk_err)
    );
`else
    logic unused_res;
    assign unused_res   = ^{res_valid, res_data};
    assign chk_mismatch = 1'b0;
    assign chk_err      = 1'b0;
`endif
endmodule

// File: tb/tb_dot_vec_serializer.sv
// tb_dot_vec_serializer: scoreboard bench for dot_vec_serializer with a simple
// engine model returning each frame's dot product at the following phase 0.
module tb_dot_vec_serializer;
    import dot_pkg::*;
    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, frame_start, frame_last, res_valid;
    logic        chk_mismatch, chk_err;
    logic [23:0] in_a, in_b, ta, tb;
    logic [7:0]  byte_o;
    logic [15:0] frames_sent;
    logic [17:0] res_data;

    dot_vec_serializer dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .byte_o       (byte_o),
        .frame_start  (frame_start),
        .frame_last   (frame_last),
        .frames_sent  (frames_sent),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .chk_mismatch (chk_mismatch),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    int          ph, n5, k;
    bit          m_full, cur_live, m_err, corrupt, last_acc;
    logic [47:0] cur_frame;
    logic [47:0] q[$];
    logic [15:0] m_sent;
    logic [17:0] prev_dot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; n5 = 0; m_full = 0; cur_live = 0; m_err = 0;
        cur_frame = '0; m_sent = '0; prev_dot = '0;
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; in_valid = 1'b0; res_valid = 1'b0; corrupt = 0;
        #1;
        check("rst_byte", 32'(byte_o), 0);
        check("rst_start", 32'(frame_start), 0);
        check("rst_last", 32'(frame_last), 0);
        check("rst_sent", 32'(frames_sent), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_mismatch", 32'(chk_mismatch), 0);
        check("rst_err", 32'(chk_err), 0);
        @(posedge clk);
        #2 resetn = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic v, input logic [23:0] a, input logic [23:0] b);
        bit exp_ready, acc, mism;
        @(negedge clk);
        res_valid = (ph == 0) && (n5 >= 1);
        res_data  = prev_dot - 18'(corrupt);
        in_valid  = v; in_a = a; in_b = b;
        #1;
        exp_ready = !m_full || ph == 5;
`ifdef DOT_RESULT_CHECK_EN
        mism = (n5 >= 2) && ph == 0 && corrupt;
`else
        mism = 0;
`endif
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("byte_o", 32'(byte_o), 32'(cur_frame[ph*8 +: 8]));
        check("frame_start", 32'(frame_start), 32'(cur_live && ph == 0));
        check("frame_last", 32'(frame_last), 32'(ph == 5));
        check("frames_sent", 32'(frames_sent), 32'(m_sent));
        check("chk_mismatch", 32'(chk_mismatch), 32'(mism));
        check("chk_err", 32'(chk_err), 32'(m_err));
        m_err = m_err | mism;
        acc = v && exp_ready;
        last_acc = acc;
        if (ph == 5) begin
            prev_dot = dot3(cur_frame[23:0], cur_frame[47:24]);
            n5++;
            if (m_full) begin
                cur_frame = q.pop_front();
                cur_live = 1;
                m_sent++;
            end else begin
                cur_frame = '0;
                cur_live = 0;
            end
            m_full = acc;
        end else begin
            m_full = m_full | acc;
        end
        if (acc) q.push_back({b, a});
        ph = (ph == 5) ? 0 : ph + 1;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        res_valid = 1'b0; res_data = '0; corrupt = 0;
        do_reset();
        repeat (12) step(0, '0, '0);
        while (ph != 2) step(0, '0, '0);
        step(1, {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
        check("accept_ph2", 32'(last_acc), 1);
        repeat (14) step(0, '0, '0);
        k = 0;
        for (int s = 0; s < 60 && k < 5; s++) begin
            ta = {8'(k*3+3), 8'(k*3+2), 8'(k*3+1)};
            tb = {8'(k+40), 8'(k+30), 8'(k+20)};
            step(1, ta, tb);
            if (last_acc) k++;
        end
        check("sustained_accepts", 32'(k), 5);
        repeat (14) step(0, '0, '0);
        k = 0;
        for (int s = 0; s < 12 && k == 0; s++) begin
            step(1, 24'hFFFFFF, 24'hFFFFFF);
            if (last_acc) k++;
        end
        check("max_accept", 32'(k), 1);
        repeat (14) step(0, '0, '0);
        step(1, {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
        for (int s = 0; s < 20 && !(ph == 0 && n5 >= 2 && prev_dot == 18'd32); s++) step(0, '0, '0);
        corrupt = 1;
        step(0, '0, '0);
        corrupt = 0;
        repeat (14) step(0, '0, '0);
        k = 0;
        for (int s = 0; s < 40 && !(cur_live && m_full && ph == 3); s++) begin
            ta = {8'(k+9), 8'(k+8), 8'(k+7)};
            tb = {8'(k+12), 8'(k+11), 8'(k+10)};
            step(1, ta, tb);
            if (last_acc) k++;
        end
        check("pre_reset_hold", 32'(m_full && cur_live && ph == 3), 1);
        do_reset();
        repeat (14) step(0, '0, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
